fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: IDLE/FETCH/HOLD instruction fetch stage.
// Issues imem requests at PC, holds the returned word for decode
// until accepted, then steps PC by +4, branch offset or jump target.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   imem_req/addr/ack/rdata    instruction memory request/response
//   instr, opCode, pc_out      held instruction, its opcode, its address
//   instr_valid, instr_ready   decode handshake
//   Jump, Branch, Zero         redirect controls, sampled on handoff
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opCode,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [31:0] pc;
  logic [31:0] instrQ;
  logic [31:0] pcOutQ;
  logic [31:0] pcPlus4;
  logic [31:0] brOffset;
  logic [31:0] nextPc;
  logic        capture;
  logic        handoff;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    stateNext = FETCH;
      FETCH:   if (imem_ack) stateNext = HOLD;
      HOLD:    if (instr_ready) stateNext = FETCH;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state == FETCH);
    instr_valid = (state == HOLD);
  end

  assign capture = (state == FETCH) && imem_ack;
  assign handoff = (state == HOLD) && instr_ready;

  // Redirect is computed from the held word and its own address.
  assign pcPlus4  = pcOutQ + 32'd4;
  assign brOffset = {{14{instrQ[15]}}, instrQ[15:0], 2'b00};

  always_comb begin
    nextPc = pcPlus4;
    if (Jump) begin
      nextPc = {pcPlus4[31:28], instrQ[25:0], 2'b00};
    end else if (Branch && Zero) begin
      nextPc = pcPlus4 + brOffset;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      pcOutQ <= RESET_PC;
      instrQ <= '0;
    end else begin
      if (capture) begin
        instrQ <= imem_rdata;
        pcOutQ <= pc;
      end
      if (handoff) begin
        pc <= nextPc;
      end
    end
  end

  assign imem_addr = pc;
  assign instr     = instrQ;
  assign opCode    = instrQ[31:26];
  assign pc_out    = pcOutQ;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit.
// Three instances in lockstep exercise different RESET_PC values.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ack = 1'b0;
  logic [31:0] rdata = '0;
  logic        ready = 1'b0;
  logic        jump = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;

  logic        reqA, validA;
  logic [31:0] addrA, instrA, pcA;
  logic [5:0]  opA;
  logic        reqB, validB;
  logic [31:0] addrB, instrB, pcB;
  logic [5:0]  opB;
  logic        reqC, validC;
  logic [31:0] addrC, instrC, pcC;
  logic [5:0]  opC;

  int total = 0;
  int bad = 0;

  logic [31:0] expAddrQ[$];
  logic [31:0] expInstrQ[$];
  logic [31:0] expPcQ[$];
  logic [31:0] expAddr;
  logic [31:0] sa;
  bit          ok;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dutA (
    .clk(clk), .reset(reset),
    .imem_req(reqA), .imem_addr(addrA),
    .imem_ack(ack), .imem_rdata(rdata),
    .instr(instrA), .opCode(opA), .pc_out(pcA),
    .instr_valid(validA), .instr_ready(ready),
    .Jump(jump), .Branch(branch), .Zero(zero)
  );

  fetch_unit #(.RESET_PC(32'hF000_0000)) u_dutB (
    .clk(clk), .reset(reset),
    .imem_req(reqB), .imem_addr(addrB),
    .imem_ack(ack), .imem_rdata(rdata),
    .instr(instrB), .opCode(opB), .pc_out(pcB),
    .instr_valid(validB), .instr_ready(ready),
    .Jump(jump), .Branch(branch), .Zero(zero)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dutC (
    .clk(clk), .reset(reset),
    .imem_req(reqC), .imem_addr(addrC),
    .imem_ack(ack), .imem_rdata(rdata),
    .instr(instrC), .opCode(opC), .pc_out(pcC),
    .instr_valid(validC), .instr_ready(ready),
    .Jump(jump), .Branch(branch), .Zero(zero)
  );

  // Stimulus helpers: all start and end on a falling edge.
  task automatic applyReset();
    reset = 1'b1; ack = 1'b0; ready = 1'b0;
    jump = 1'b0; branch = 1'b0; zero = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic serveFetch(input logic [31:0] word,
                            output logic [31:0] seenAddr,
                            output bit seenOk);
    seenOk = 1'b0;
    seenAddr = '0;
    for (int k = 0; k < 20; k++) begin
      if (reqA === 1'b1) begin
        seenOk = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (seenOk) begin
      seenAddr = addrA;
      ack = 1'b1;
      rdata = word;
      @(negedge clk);
      ack = 1'b0;
      rdata = '0;
    end
  endtask

  task automatic doHandoff(input logic j, input logic b, input logic z);
    ready = 1'b1; jump = j; branch = b; zero = z;
    @(negedge clk);
    ready = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ack = 1'b0; ready = 1'b0;
    @(negedge clk);
    total++;
    if (reqA !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b want=0", reqA); end
    total++;
    if (validA !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", validA); end
    total++;
    if (addrA !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", addrA); end
    total++;
    if (instrA !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", instrA); end
    total++;
    if (opA !== 6'h0) begin bad++; $display("FAIL rst_op got=%h want=0", opA); end
    total++;
    if (pcA !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", pcA); end
    total++;
    if (addrC !== 32'hFFFF_FFFC) begin bad++; $display("FAIL rst_addrC got=%h want=fffffffc", addrC); end
    total++;
    if (pcB !== 32'hF000_0000) begin bad++; $display("FAIL rst_pcB got=%h want=f0000000", pcB); end
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (reqA !== 1'b1 || validA !== 1'b0) begin
      bad++; $display("FAIL rst_to_fetch got req=%0b valid=%0b want 1/0", reqA, validA);
    end
  endtask

  task automatic test_fetch_latency();
    applyReset();
    expAddrQ.push_back(32'h0);
    expInstrQ.push_back(32'h2008_0005);
    expPcQ.push_back(32'h0);
    expAddr = expAddrQ.pop_front();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (reqA !== 1'b1 || addrA !== expAddr || validA !== 1'b0) begin
        bad++;
        $display("FAIL lat_wait%0d got req=%0b addr=%h want 1 %h", i, reqA, addrA, expAddr);
      end
      if (i == 3) begin
        ack = 1'b1;
        rdata = 32'h2008_0005;
      end
      @(negedge clk);
    end
    ack = 1'b0;
    rdata = '0;
    total++;
    if (validA !== 1'b1) begin bad++; $display("FAIL lat_valid got=%0b want=1", validA); end
    total++;
    if (opA !== 6'b001000) begin bad++; $display("FAIL lat_op got=%b want=001000", opA); end
    expAddr = expInstrQ.pop_front();
    total++;
    if (instrA !== expAddr) begin bad++; $display("FAIL lat_instr got=%h want=%h", instrA, expAddr); end
    expAddr = expPcQ.pop_front();
    total++;
    if (pcA !== expAddr) begin bad++; $display("FAIL lat_pc got=%h want=%h", pcA, expAddr); end
  endtask

  task automatic test_hold_stall();
    // Stray acks while holding must not disturb the held word.
    for (int i = 0; i < 5; i++) begin
      ack = 1'b1;
      rdata = 32'hDEAD_0000 + i;
      @(negedge clk);
      total++;
      if (instrA !== 32'h2008_0005 || pcA !== 32'h0 || reqA !== 1'b0 || validA !== 1'b1) begin
        bad++;
        $display("FAIL hold%0d got instr=%h pc=%h req=%0b v=%0b", i, instrA, pcA, reqA, validA);
      end
    end
    ack = 1'b0;
    rdata = '0;
    expAddrQ.push_back(32'h4);
    doHandoff(1'b0, 1'b0, 1'b0);
    expAddr = expAddrQ.pop_front();
    total++;
    if (addrA !== expAddr || reqA !== 1'b1 || validA !== 1'b0) begin
      bad++;
      $display("FAIL hold_next got addr=%h req=%0b v=%0b want %h 1 0", addrA, reqA, validA, expAddr);
    end
  endtask

  task automatic test_branch();
    // Jump from 4 to 0x10, then branch taken and not taken from 0x10.
    serveFetch(32'h0800_0004, sa, ok);
    expAddrQ.push_back(32'h10);
    doHandoff(1'b1, 1'b0, 1'b0);
    expAddr = expAddrQ.pop_front();
    total++;
    if (addrA !== expAddr) begin bad++; $display("FAIL jmp10 got=%h want=%h", addrA, expAddr); end
    expPcQ.push_back(32'h10);
    serveFetch(32'h1000_FFFE, sa, ok);
    expAddr = expPcQ.pop_front();
    total++;
    if (!ok || pcA !== expAddr) begin bad++; $display("FAIL br_pc got=%h want=%h", pcA, expAddr); end
    expAddrQ.push_back(32'h0000_000C);
    doHandoff(1'b0, 1'b1, 1'b1);
    expAddr = expAddrQ.pop_front();
    total++;
    if (addrA !== expAddr) begin bad++; $display("FAIL br_taken got=%h want=%h", addrA, expAddr); end
    serveFetch(32'h0000_0000, sa, ok);
    doHandoff(1'b0, 1'b0, 1'b1);
    total++;
    if (addrA !== 32'h10) begin bad++; $display("FAIL br_zero_only got=%h want=10", addrA); end
    serveFetch(32'h1000_FFFE, sa, ok);
    expAddrQ.push_back(32'h0000_0014);
    doHandoff(1'b0, 1'b1, 1'b0);
    expAddr = expAddrQ.pop_front();
    total++;
    if (addrA !== expAddr) begin bad++; $display("FAIL br_not_taken got=%h want=%h", addrA, expAddr); end
  endtask

  task automatic test_jump_priority();
    applyReset();
    serveFetch(32'h0800_0040, sa, ok);
    total++;
    if (!ok || pcB !== 32'hF000_0000 || instrB !== 32'h0800_0040) begin
      bad++; $display("FAIL jp_held got pc=%h instr=%h", pcB, instrB);
    end
    expAddrQ.push_back(32'hF000_0100);
    doHandoff(1'b1, 1'b1, 1'b1);
    expAddr = expAddrQ.pop_front();
    total++;
    if (addrB !== expAddr) begin bad++; $display("FAIL jp_target got=%h want=%h", addrB, expAddr); end
    total++;
    if (addrA !== 32'h0000_0100) begin bad++; $display("FAIL jp_targetA got=%h want=100", addrA); end
  endtask

  task automatic test_wrap();
    applyReset();
    serveFetch(32'h0000_0000, sa, ok);
    total++;
    if (!ok || pcC !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc got=%h want=fffffffc", pcC); end
    expAddrQ.push_back(32'h0);
    doHandoff(1'b0, 1'b0, 1'b0);
    expAddr = expAddrQ.pop_front();
    total++;
    if (addrC !== expAddr) begin bad++; $display("FAIL wrap_next got=%h want=%h", addrC, expAddr); end
  endtask

  task automatic test_reset_override();
    applyReset();
    serveFetch(32'h0800_0040, sa, ok);
    reset = 1'b1; ready = 1'b1; jump = 1'b1;
    @(negedge clk);
    reset = 1'b0; ready = 1'b0; jump = 1'b0;
    total++;
    if (validA !== 1'b0 || instrA !== 32'h0 || pcA !== 32'h0 || reqA !== 1'b0) begin
      bad++; $display("FAIL rst_handoff got v=%0b instr=%h pc=%h", validA, instrA, pcA);
    end
    @(negedge clk);
    total++;
    if (reqA !== 1'b1 || addrA !== 32'h0) begin bad++; $display("FAIL rst_handoff_fetch got=%h want=0", addrA); end
    reset = 1'b1; ack = 1'b1; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    reset = 1'b0; ack = 1'b0; rdata = '0;
    total++;
    if (validA !== 1'b0 || instrA !== 32'h0 || opA !== 6'h0 || reqA !== 1'b0) begin
      bad++; $display("FAIL rst_ack got v=%0b instr=%h req=%0b", validA, instrA, reqA);
    end
    @(negedge clk);
    total++;
    if (reqA !== 1'b1 || addrA !== 32'h0 || validA !== 1'b0) begin
      bad++; $display("FAIL rst_ack_fetch got req=%0b addr=%h", reqA, addrA);
    end
    serveFetch(32'h0, sa, ok);
    doHandoff(1'b0, 1'b0, 1'b0);
    total++;
    if (addrA !== 32'h4) begin bad++; $display("FAIL midfetch_pre got=%h want=4", addrA); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (reqA !== 1'b1 || addrA !== 32'h0) begin bad++; $display("FAIL midfetch_abandon got=%h want=0", addrA); end
  endtask

  initial begin
    test_reset();
    test_fetch_latency();
    test_hold_stall();
    test_branch();
    test_jump_priority();
    test_wrap();
    test_reset_override();
    total++;
    if (expAddrQ.size() != 0 || expInstrQ.size() != 0 || expPcQ.size() != 0) begin
      bad++; $display("FAIL scoreboard_left got=%0d want=0", expAddrQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
